// File: rtl/motion_update_scheduler.sv
// Sequences one motion-update pass over every cell cache, x-outer, z-inner.
// Define MU_SCHED_TIMEOUT_EN to add a drain watchdog.
module motion_update_scheduler #(
  parameter int DATA_WIDTH     = 32,
  parameter int CELL_ID_WIDTH  = 4,
  parameter int ADDR_WIDTH     = 8,
  parameter int CELL_DIM_X     = 4,
  parameter int CELL_DIM_Y     = 4,
  parameter int CELL_DIM_Z     = 4,
  parameter int MAX_PARTICLES  = 219,
  parameter int CNT_WIDTH      = 16,
  parameter int SWAP_GUARD     = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_mu_ready,
  input  logic                       in_mu_result_valid,
  input  logic [3*DATA_WIDTH-1:0]    in_rd_data,
  output logic                       out_motion_update_enable,
  output logic [3*CELL_ID_WIDTH-1:0] out_rd_cell_id,
  output logic [ADDR_WIDTH-1:0]      out_rd_address,
  output logic                       out_rden,
  output logic                       out_issue_valid,
  output logic [3*CELL_ID_WIDTH-1:0] out_issue_cell_id,
  output logic                       out_busy,
  output logic                       out_done,
  output logic                       out_error,
  output logic [CNT_WIDTH-1:0]       out_particle_total
);

  typedef enum logic [2:0] {
    IDLE, RD_CNT, WAIT_CNT, STREAM,
    NEXT_CELL, DRAIN, GUARD, DONE
  } state_t;

  localparam logic [CELL_ID_WIDTH-1:0] ID1 = CELL_ID_WIDTH'(1);
  localparam logic [CELL_ID_WIDTH-1:0] DX = CELL_ID_WIDTH'(CELL_DIM_X);
  localparam logic [CELL_ID_WIDTH-1:0] DY = CELL_ID_WIDTH'(CELL_DIM_Y);
  localparam logic [CELL_ID_WIDTH-1:0] DZ = CELL_ID_WIDTH'(CELL_DIM_Z);
  localparam logic [ADDR_WIDTH-1:0] MAXP = ADDR_WIDTH'(MAX_PARTICLES);
  localparam logic [ADDR_WIDTH-1:0] A1 = ADDR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] C1 = CNT_WIDTH'(1);
  localparam logic [7:0] GLAST = 8'(SWAP_GUARD - 1);

  state_t state;
  logic [CELL_ID_WIDTH-1:0] cx, cy, cz;
  logic [ADDR_WIDTH-1:0] idx, count;
  logic [CNT_WIDTH-1:0] outstanding;
  logic [7:0] gcnt;
  logic rd_stream, res_ok, last_cell;
  logic [ADDR_WIDTH-1:0] rd_count;

`ifdef MU_SCHED_TIMEOUT_EN
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] wd;
  logic unused_bits;
  assign unused_bits = ^in_rd_data[3*DATA_WIDTH-1:ADDR_WIDTH];
`else
  logic unused_bits;
  assign unused_bits = ^{in_rd_data[3*DATA_WIDTH-1:ADDR_WIDTH],
                         TIMEOUT_CYCLES[0]};
`endif

  assign rd_count  = in_rd_data[ADDR_WIDTH-1:0];
  assign rd_stream = (state == STREAM) && in_mu_ready;
  assign res_ok    = in_mu_result_valid && out_motion_update_enable;
  assign last_cell = (cx == DX) && (cy == DY) && (cz == DZ);

  assign out_rden       = (state == RD_CNT) || rd_stream;
  assign out_rd_address = (state == STREAM) ? idx : '0;
  assign out_rd_cell_id = out_busy ? {cx, cy, cz} : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cx <= ID1;
      cy <= ID1;
      cz <= ID1;
      idx <= '0;
      count <= '0;
      outstanding <= '0;
      gcnt <= '0;
      out_motion_update_enable <= 1'b0;
      out_issue_valid <= 1'b0;
      out_issue_cell_id <= '0;
      out_busy <= 1'b0;
      out_done <= 1'b0;
      out_error <= 1'b0;
      out_particle_total <= '0;
`ifdef MU_SCHED_TIMEOUT_EN
      wd <= '0;
`endif
    end else begin
      out_done <= 1'b0;
      out_issue_valid <= rd_stream;
      if (rd_stream) out_issue_cell_id <= {cx, cy, cz};
      if (out_issue_valid)
        out_particle_total <= out_particle_total + C1;
      // results outside an enabled pass are dropped and flagged
      if (in_mu_result_valid && !out_motion_update_enable)
        out_error <= 1'b1;
      if (out_issue_valid && !res_ok) begin
        outstanding <= outstanding + C1;
      end else if (!out_issue_valid && res_ok) begin
        if (outstanding == '0) out_error <= 1'b1;
        else outstanding <= outstanding - C1;
      end
      unique case (state)
        IDLE: if (start) begin
          out_motion_update_enable <= 1'b1;
          out_busy <= 1'b1;
          out_error <= 1'b0;
          out_particle_total <= '0;
          cx <= ID1;
          cy <= ID1;
          cz <= ID1;
`ifdef MU_SCHED_TIMEOUT_EN
          wd <= '0;
`endif
          state <= RD_CNT;
        end
        RD_CNT: state <= WAIT_CNT;
        WAIT_CNT: begin
          if (rd_count > MAXP) begin
            count <= MAXP;
            out_error <= 1'b1;
          end else begin
            count <= rd_count;
          end
          idx <= A1;
          state <= (rd_count == '0) ? NEXT_CELL : STREAM;
        end
        STREAM: if (in_mu_ready) begin
          if (idx == count) state <= NEXT_CELL;
          else idx <= idx + A1;
        end
        NEXT_CELL: begin
          if (cz != DZ) begin
            cz <= cz + ID1;
          end else begin
            cz <= ID1;
            if (cy != DY) begin
              cy <= cy + ID1;
            end else begin
              cy <= ID1;
              cx <= (cx != DX) ? cx + ID1 : ID1;
            end
          end
          state <= last_cell ? DRAIN : RD_CNT;
        end
        DRAIN: begin
`ifdef MU_SCHED_TIMEOUT_EN
          wd <= wd + 32'd1;
          if (outstanding == '0) begin
            out_motion_update_enable <= 1'b0;
            gcnt <= '0;
            state <= GUARD;
          end else if (wd == WD_LAST) begin
            out_error <= 1'b1;
            outstanding <= '0;
            out_motion_update_enable <= 1'b0;
            gcnt <= '0;
            state <= GUARD;
          end
`else
          if (outstanding == '0) begin
            out_motion_update_enable <= 1'b0;
            gcnt <= '0;
            state <= GUARD;
          end
`endif
        end
        GUARD: begin
          if (gcnt == GLAST) begin
            out_done <= 1'b1;
            state <= DONE;
          end else begin
            gcnt <= gcnt + 8'd1;
          end
        end
        DONE: begin
          out_busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_motion_update_scheduler.sv
// Directed bench for motion_update_scheduler: cache and pipeline models,
// table of pass scenarios plus reset and watchdog sequences.
module tb_motion_update_scheduler;

  localparam int NC = 64;
  localparam int SG = 3;
  localparam int MAXP = 219;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic ready = 1'b0;
  logic res_valid = 1'b0;
  logic [95:0] rd_data = '0;
  logic enable, rden, issue_valid, busy, done, error;
  logic [11:0] rd_cell_id, issue_cell_id;
  logic [7:0] rd_address;
  logic [15:0] total;

  motion_update_scheduler dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .in_mu_ready(ready),
    .in_mu_result_valid(res_valid),
    .in_rd_data(rd_data),
    .out_motion_update_enable(enable),
    .out_rd_cell_id(rd_cell_id),
    .out_rd_address(rd_address),
    .out_rden(rden),
    .out_issue_valid(issue_valid),
    .out_issue_cell_id(issue_cell_id),
    .out_busy(busy),
    .out_done(done),
    .out_error(error),
    .out_particle_total(total)
  );

  always #5 clk = ~clk;

  typedef struct {
    int base;
    int sel;
    int special;
    int rmode;
    int delay;
    int exp_total;
    int exp_err;
    int exp_gap;
  } vec_t;

  vec_t vecs[7];
  int n_vec = 0;
  int n_bad = 0;
  int cnt[NC];
  int rd_seen[NC][256];
  int is_seen[NC][256];
  int order_q[$];
  int cyc, sr, done_cnt, guard_low, last_res, en_fall;
  int last_iss, done_cyc, tag_bad;
  logic [95:0] rd_next = '0;
  bit drop_one = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int cidx(input logic [11:0] id);
    return (int'(id[11:8]) - 1) * 16 + (int'(id[7:4]) - 1) * 4
           + int'(id[3:0]) - 1;
  endfunction

  task automatic tick(input int rmode, input int delay);
    int c, a;
    @(posedge clk);
    #1;
    cyc++;
    rd_data = rd_next;
    if (rmode == 2) ready = ~ready;
    else ready = (rmode == 1);
    res_valid = sr[delay-1];
    if (res_valid && drop_one) begin
      res_valid = 1'b0;
      drop_one = 1'b0;
    end
    #1;
    if (res_valid) last_res = cyc;
    if (rden) begin
      c = cidx(rd_cell_id);
      a = int'(rd_address);
      if (c < 0 || c >= NC) begin
        tag_bad++;
      end else begin
        rd_seen[c][a]++;
        if (a == 0) begin
          order_q.push_back(c);
          rd_next = {88'hFF_FFFF_FFFF_FFFF_FFFF_FFFF, 8'(cnt[c])};
        end else begin
          rd_next = {80'h1234_5678_9ABC_DEF0_1357, 8'(c), 8'(a)};
        end
      end
    end
    if (issue_valid) begin
      last_iss = cyc;
      c = int'(rd_data[15:8]);
      a = int'(rd_data[7:0]);
      if (c >= NC || c != cidx(issue_cell_id)) tag_bad++;
      else is_seen[c][a]++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy && !enable && !done) guard_low++;
    if (busy && !enable && en_fall < 0) en_fall = cyc;
    sr = (sr << 1) | int'(issue_valid);
  endtask

  task automatic clear_model();
    order_q.delete();
    sr = 0;
    done_cnt = 0;
    guard_low = 0;
    last_res = -1;
    en_fall = -1;
    last_iss = -1;
    done_cyc = -1;
    tag_bad = 0;
    cyc = 0;
    for (int c = 0; c < NC; c++)
      for (int a = 0; a < 256; a++) begin
        rd_seen[c][a] = 0;
        is_seen[c][a] = 0;
      end
  endtask

  task automatic run_pass(input vec_t v, input string tag);
    int nmax, bad_rd, bad_is, bad_ord;
    for (int c = 0; c < NC; c++) cnt[c] = v.base;
    cnt[v.sel] = v.special;
    clear_model();
    start = 1'b1;
    tick(v.rmode, v.delay);
    start = 1'b0;
    while (done_cnt == 0 && cyc < 20000) begin
      // a second start while busy must be ignored
      if (cyc == 10) start = 1'b1;
      tick(v.rmode, v.delay);
      start = 1'b0;
    end
    repeat (4) tick(v.rmode, v.delay);
    bad_rd = 0;
    bad_is = 0;
    bad_ord = 0;
    for (int c = 0; c < NC; c++) begin
      nmax = (cnt[c] > MAXP) ? MAXP : cnt[c];
      for (int a = 0; a < 256; a++) begin
        if (rd_seen[c][a] != ((a <= nmax) ? 1 : 0)) bad_rd++;
        if (is_seen[c][a] != ((a >= 1 && a <= nmax) ? 1 : 0)) bad_is++;
      end
    end
    if (order_q.size() != NC) bad_ord = NC;
    else for (int i = 0; i < NC; i++) if (order_q[i] != i) bad_ord++;
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_total"}, int'(total), v.exp_total);
    check({tag, "_error"}, int'(error), v.exp_err);
    check({tag, "_busy_after"}, int'(busy), 0);
    check({tag, "_enable_after"}, int'(enable), 0);
    check({tag, "_guard_cycles"}, guard_low, SG);
    check({tag, "_tag_errors"}, tag_bad, 0);
    check({tag, "_read_map"}, bad_rd, 0);
    check({tag, "_issue_map"}, bad_is, 0);
    check({tag, "_cell_order"}, bad_ord, 0);
    if (v.exp_gap >= 0)
      check({tag, "_drain_exit"}, en_fall - last_res, v.exp_gap);
  endtask

  initial begin
    vecs[0] = '{2, 0, 2, 1, 5, 128, 0, -1};
    vecs[1] = '{1, 0, 0, 1, 3, 63, 0, -1};
    vecs[2] = '{0, 0, 5, 2, 2, 5, 0, -1};
    vecs[3] = '{0, 5, 250, 1, 4, 219, 1, -1};
    vecs[4] = '{0, 63, 20, 1, 1, 20, 0, 2};
    vecs[5] = '{0, 0, 0, 1, 1, 0, 0, -1};
    vecs[6] = '{0, 63, 219, 2, 7, 219, 0, -1};

    repeat (3) @(posedge clk);
    #1;
    check("reset_enable", int'(enable), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_rden", int'(rden), 0);
    check("reset_total", int'(total), 0);
    check("reset_cell", int'(rd_cell_id), 0);
    check("reset_error", int'(error), 0);
    rst = 1'b1;

    for (int c = 0; c < NC; c++) cnt[c] = 2;
    clear_model();
    start = 1'b1;
    tick(1, 5);
    start = 1'b0;
    while (int'(total) < 2 && cyc < 500) tick(1, 5);
    check("mid_busy_before", int'(busy), 1);
    rst = 1'b0;
    #1;
    check("mid_rst_enable", int'(enable), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_rden", int'(rden), 0);
    check("mid_rst_total", int'(total), 0);
    check("mid_rst_issue_cell", int'(issue_cell_id), 0);
    check("mid_rst_cell", int'(rd_cell_id), 0);
    @(posedge clk);
    #3;
    rst = 1'b1;

    for (int i = 0; i < 7; i++) run_pass(vecs[i], $sformatf("v%0d", i));

`ifdef MU_SCHED_TIMEOUT_EN
    drop_one = 1'b1;
    run_pass('{0, 63, 3, 1, 2, 3, 1, -1}, "timeout");
    check("timeout_latency", done_cyc - last_iss, 4096 + SG + 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
